// File: rtl/i2s_capture.sv
// I2S ADC receive path: deserializes stereo samples, packs four pairs per
// 128-bit word and streams them into a circular SDRAM region.
module i2s_capture #(
   parameter logic [21:0] BASE_ADDR   = 22'h200000,
   parameter logic [21:0] BUF_WORDS   = 22'd65536,
   parameter int          SAMPLE_BITS = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         SClk,
   input  logic         LRClk,
   input  logic         Din,
   input  logic         enable,
   input  logic         sdram_wait,
   input  logic         sdram_ac,
   output logic         sdram_wr,
   output logic [21:0]  sdram_addr,
   output logic [127:0] sdram_data,
   output logic [15:0]  sdram_be,
   output logic         busy,
   output logic         write_done,
   output logic         wrap,
   output logic         overflow
);

   localparam int SW = SAMPLE_BITS;
   localparam int CW = $clog2(SW + 1);
   localparam logic [21:0] LAST_ADDR = BASE_ADDR + BUF_WORDS - 22'd1;

   typedef enum logic {IDLE, REQ} state_e;

   logic [2:0]    sclk_s_q;
   logic [1:0]    lr_s_q;
   logic [1:0]    din_s_q;
   logic          en_q;

   logic          lr_last_q, lr_last_d;
   logic          chan_q, chan_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] shift_q, shift_d;
   logic [15:0]   l_q, l_d;
   logic          armed_q, armed_d;
   logic [1:0]    idx_q, idx_d;
   logic [127:0]  pack_q, pack_d;

   logic [127:0]  f0_q, f0_d;
   logic [127:0]  f1_q, f1_d;
   logic [1:0]    fcnt_q, fcnt_d;

   state_e        state_q, state_d;
   logic          wr_q, wr_d;
   logic [21:0]   addr_q, addr_d;
   logic [127:0]  data_q, data_d;
   logic          done_q, done_d;
   logic          wrap_q, wrap_d;
   logic          ovf_q, ovf_d;
   logic          pend_q, pend_d;

   logic          sclk_rise;
   logic          lr_s;
   logic          din_s;
   logic          en_rise;
   logic [SW-1:0] smp;
   logic          smp_done;
   logic          push;
   logic          pop;
   logic [31:0]   pair;

   assign sclk_rise = sclk_s_q[1] & ~sclk_s_q[2];
   assign lr_s      = lr_s_q[1];
   assign din_s     = din_s_q[1];
   assign en_rise   = enable & ~en_q;
   assign smp       = {shift_q[SW-2:0], din_s};

   // Serial framing, channel latch and pair packing
   always_comb begin
      lr_last_d = lr_last_q;
      chan_d    = chan_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      l_d       = l_q;
      armed_d   = armed_q;
      idx_d     = idx_q;
      pack_d    = pack_q;
      smp_done  = 1'b0;
      push      = 1'b0;
      pair      = {l_q, 16'(smp)};
      if (sclk_rise) begin
         lr_last_d = lr_s;
         if (lr_s != lr_last_q) begin
            cnt_d  = '0;
            chan_d = lr_s;
            if (!lr_s && enable) begin
               armed_d = 1'b1;
            end
         end else if (cnt_q < CW'(SW)) begin
            shift_d  = smp;
            cnt_d    = cnt_q + 1'b1;
            smp_done = (cnt_q == CW'(SW - 1));
         end
      end
      if (smp_done && armed_q) begin
         if (!chan_q) begin
            l_d = 16'(smp);
         end else begin
            unique case (idx_q)
               2'd0:    pack_d[127:96] = pair;
               2'd1:    pack_d[95:64]  = pair;
               2'd2:    pack_d[63:32]  = pair;
               default: pack_d[31:0]   = pair;
            endcase
            idx_d = idx_q + 2'd1;
            push  = (idx_q == 2'd3);
         end
      end
      // Disabled: partial word and samples never survive to a new arm
      if (!enable) begin
         armed_d = 1'b0;
         idx_d   = '0;
         pack_d  = '0;
         l_d     = '0;
         push    = 1'b0;
      end
   end

   // Write FSM and two-entry word FIFO
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      ovf_d   = ovf_q;
      pend_d  = pend_q | en_rise;
      f0_d    = f0_q;
      f1_d    = f1_q;
      fcnt_d  = fcnt_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fcnt_q != 2'd0 && !sdram_wait) begin
               state_d = REQ;
               wr_d    = 1'b1;
               data_d  = f0_q;
               pop     = 1'b1;
            end
         end
         REQ: begin
            if (sdram_ac) begin
               state_d = IDLE;
               wr_d    = 1'b0;
               done_d  = 1'b1;
               if (addr_q == LAST_ADDR) begin
                  addr_d = BASE_ADDR;
                  wrap_d = 1'b1;
               end else begin
                  addr_d = addr_q + 22'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      case ({push, pop})
         2'b11: begin
            if (fcnt_q == 2'd1) begin
               f0_d = pack_d;
            end else begin
               f0_d = f1_q;
               f1_d = pack_d;
            end
         end
         2'b01: begin
            f0_d   = f1_q;
            fcnt_d = fcnt_q - 2'd1;
         end
         2'b10: begin
            if (fcnt_q == 2'd0) begin
               f0_d   = pack_d;
               fcnt_d = 2'd1;
            end else if (fcnt_q == 2'd1) begin
               f1_d   = pack_d;
               fcnt_d = 2'd2;
            end else begin
               ovf_d = 1'b1;
            end
         end
         default: ;
      endcase
      // A restart waits until nothing from the previous run is in flight
      if (pend_d && state_q == IDLE && fcnt_q == 2'd0) begin
         addr_d = BASE_ADDR;
         ovf_d  = 1'b0;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_s_q  <= '0;
         lr_s_q    <= '0;
         din_s_q   <= '0;
         en_q      <= 1'b0;
         lr_last_q <= 1'b0;
         chan_q    <= 1'b0;
         cnt_q     <= '0;
         shift_q   <= '0;
         l_q       <= '0;
         armed_q   <= 1'b0;
         idx_q     <= '0;
         pack_q    <= '0;
         f0_q      <= '0;
         f1_q      <= '0;
         fcnt_q    <= '0;
         state_q   <= IDLE;
         wr_q      <= 1'b0;
         addr_q    <= BASE_ADDR;
         data_q    <= '0;
         done_q    <= 1'b0;
         wrap_q    <= 1'b0;
         ovf_q     <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         sclk_s_q  <= {sclk_s_q[1:0], SClk};
         lr_s_q    <= {lr_s_q[0], LRClk};
         din_s_q   <= {din_s_q[0], Din};
         en_q      <= enable;
         lr_last_q <= lr_last_d;
         chan_q    <= chan_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         l_q       <= l_d;
         armed_q   <= armed_d;
         idx_q     <= idx_d;
         pack_q    <= pack_d;
         f0_q      <= f0_d;
         f1_q      <= f1_d;
         fcnt_q    <= fcnt_d;
         state_q   <= state_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         done_q    <= done_d;
         wrap_q    <= wrap_d;
         ovf_q     <= ovf_d;
         pend_q    <= pend_d;
      end
   end

   assign sdram_wr   = wr_q;
   assign sdram_addr = addr_q;
   assign sdram_data = data_q;
   assign sdram_be   = 16'hFFFF;
   assign busy       = (state_q == REQ) | (fcnt_q != 2'd0);
   assign write_done = done_q;
   assign wrap       = wrap_q;
   assign overflow   = ovf_q;

endmodule
